// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types for the counter sequencer.
//   state_e : sequencer states IDLE / RUN / PAUSE (2-bit encoding)
//   dir_e   : counting direction, DIR_UP = 0, DIR_DOWN = 1
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: command / feedback / counter-control bundle.
//   start, stop, dir_toggle, load : 1-cycle user command pulses
//   load_value                    : new terminal value captured on load
//   count                         : counter output fed back to the sequencer
//   cnt_enable, cnt_direction,
//   cnt_max_count, cnt_clear      : drive the up/down counter
//   running, wrap_pulse           : status
// master = board/counter side, slave = counter_ctrl.
interface counter_ctrl_if #(
  parameter int unsigned WIDTH = 3
);
  logic             start;
  logic             stop;
  logic             dir_toggle;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             cnt_enable;
  logic             cnt_direction;
  logic [WIDTH-1:0] cnt_max_count;
  logic             cnt_clear;
  logic             running;
  logic             wrap_pulse;

  modport master (
    output start, stop, dir_toggle, load, load_value, count,
    input  cnt_enable, cnt_direction, cnt_max_count, cnt_clear, running, wrap_pulse
  );

  modport slave (
    input  start, stop, dir_toggle, load, load_value, count,
    output cnt_enable, cnt_direction, cnt_max_count, cnt_clear, running, wrap_pulse
  );
endinterface

// File: rtl/counter_ctrl_tick_prescaler.sv
// tick_prescaler: step-rate divider for counter_ctrl.
//   clock : system clock        reset : async active-high
//   clr   : zero the prescaler  run   : advance the prescaler
//   tick  : high while the prescaler sits at TICK_DIV-1 in run (a step is due)
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int unsigned   PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clr)      pre_d = '0;
    else if (run) pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  assign tick = run && (pre_q == LAST);
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer for the lab up/down counter.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : commands start/stop/dir_toggle/load, load_value, count feedback;
//                  drives cnt_enable/cnt_direction/cnt_max_count/cnt_clear,
//                  running and wrap_pulse (all registered).
// Optional: `define BOUNCE_MODE_EN to suppress the step due at terminal count
// and reverse direction instead (counter dwells one step period at each end).
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH       = 3,
  parameter int unsigned      TICK_DIV    = 50000000,
  parameter logic [WIDTH-1:0] DEFAULT_MAX = WIDTH'(5)
) (
  input logic           clock,
  input logic           reset,
  counter_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             clear_q, clear_d;
  logic             running_q, running_d;
  logic             arm_q, arm_d;     // a step was due at terminal count
  logic             wrap_q;
  logic             tick, pre_clr, load_take, due, term;

  // Entry into RUN restarts the step period.
  assign pre_clr = (state_q != ST_RUN) && (state_d == ST_RUN);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clock (clock),
    .reset (reset),
    .clr   (pre_clr),
    .run   (state_q == ST_RUN),
    .tick  (tick)
  );

  assign term = (dir_q == DIR_DOWN) ? (bus.count == '0) : (bus.count == max_q);
  // tick only occurs in RUN, so a stop here is always the RUN->PAUSE command.
  assign due  = tick && !bus.stop;

  always_comb begin
    state_d   = state_q;
    clear_d   = 1'b0;
    max_d     = max_q;
    load_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.stop)       state_d   = ST_IDLE;
        else if (bus.start) state_d   = ST_RUN;
        else if (bus.load)  load_take = 1'b1;
      end
      ST_RUN: begin
        if (bus.stop) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (bus.start) state_d   = ST_RUN;
        else if (bus.load)      load_take = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_take) begin
      max_d = bus.load_value;
      if (bus.load_value < bus.count) clear_d = 1'b1;
    end

    running_d = (state_d == ST_RUN);
    arm_d     = due && term;
`ifdef BOUNCE_MODE_EN
    en_d  = due && !term;
    dir_d = dir_q ^ bus.dir_toggle ^ (due && term);
`else
    en_d  = due;
    dir_d = dir_q ^ bus.dir_toggle;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      dir_q     <= DIR_UP;
      max_q     <= DEFAULT_MAX;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
      arm_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      max_q     <= max_d;
      clear_q   <= clear_d;
      running_q <= running_d;
      arm_q     <= arm_d;
      wrap_q    <= arm_q;
    end
  end

  assign bus.cnt_enable    = en_q;
  assign bus.cnt_direction = dir_q;
  assign bus.cnt_max_count = max_q;
  assign bus.cnt_clear     = clear_q;
  assign bus.running       = running_q;
  assign bus.wrap_pulse    = wrap_q;
endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;
  localparam int unsigned W  = 3;
  localparam int unsigned TD = 4;
  localparam int FIRST_GAP = TD;          // negedges from start-pulse return to first strobe
  localparam int NEXT_GAP  = TD - 1;      // from post-step sample to next strobe
  localparam int DWELL_GAP = 2 * TD - 1;  // one step period skipped

  typedef struct {
    logic [W-1:0] count;
    logic         wrap;
    int           gap;
    int           wraps;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;
  int   cyc, wr, n;

  logic clock;
  logic reset;

  counter_ctrl_if #(.WIDTH(W)) bus();

  counter_ctrl #(.WIDTH(W), .TICK_DIV(TD), .DEFAULT_MAX(3'b101)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Lab up/down counter in the loop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bus.count <= '0;
    else if (bus.cnt_clear) bus.count <= '0;
    else if (bus.cnt_enable) begin
      if (bus.cnt_direction)
        bus.count <= (bus.count == 3'd0) ? bus.cnt_max_count : bus.count - 3'd1;
      else
        bus.count <= (bus.count == bus.cnt_max_count) ? 3'd0 : bus.count + 3'd1;
    end
  end

  function automatic exp_t mk(input logic [W-1:0] c, input logic w, input int g, input int ws);
    exp_t r;
    r.count = c; r.wrap = w; r.gap = g; r.wraps = ws;
    return r;
  endfunction

  task automatic pulse(input logic s, input logic p, input logic d, input logic l);
    bus.start = s; bus.stop = p; bus.dir_toggle = d; bus.load = l;
    @(negedge clock);
    bus.start = 1'b0; bus.stop = 1'b0; bus.dir_toggle = 1'b0; bus.load = 1'b0;
  endtask

  task automatic wait_strobe(output int c, output int ws);
    c = -1; ws = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (bus.cnt_enable === 1'b1) begin c = i; break; end
      if (bus.wrap_pulse === 1'b1) ws++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.cnt_enable, bus.cnt_direction, bus.cnt_max_count, bus.cnt_clear, bus.running, bus.wrap_pulse}
        !== {1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_outputs: got en=%b dir=%b max=%0d clr=%b run=%b wrap=%b, want 0 0 5 0 0 0",
               bus.cnt_enable, bus.cnt_direction, bus.cnt_max_count, bus.cnt_clear, bus.running, bus.wrap_pulse);
    else passed++;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.count !== 3'd0 || bus.cnt_enable !== 1'b0 || bus.running !== 1'b0)
      $display("FAIL reset_idle: got count=%0d en=%b run=%b, want 0 0 0", bus.count, bus.cnt_enable, bus.running);
    else passed++;
  endtask

  task automatic test_run();
    pulse(1, 0, 0, 0);
    checks++;
    if (bus.running !== 1'b1) $display("FAIL run_entry: got running=%b, want 1", bus.running);
    else passed++;
    sb.push_back(mk(3'd1, 0, FIRST_GAP, 0));
    for (int v = 2; v <= 5; v++) sb.push_back(mk(v[W-1:0], 0, NEXT_GAP, 0));
    sb.push_back(mk(3'd0, 1, NEXT_GAP, 0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_strobe(cyc, wr);
      @(negedge clock);
      checks++;
      if (cyc !== e.gap || wr !== e.wraps || bus.count !== e.count || bus.wrap_pulse !== e.wrap)
        $display("FAIL run_step: got gap=%0d wraps=%0d count=%0d wrap=%b, want gap=%0d wraps=%0d count=%0d wrap=%b",
                 cyc, wr, bus.count, bus.wrap_pulse, e.gap, e.wraps, e.count, e.wrap);
      else passed++;
    end
  endtask

  task automatic test_pause();
    // Land stop on the cycle a step is due: that step must not be issued.
    repeat (2) @(negedge clock);
    pulse(0, 1, 0, 0);
    checks++;
    if (bus.running !== 1'b0 || bus.cnt_enable !== 1'b0)
      $display("FAIL pause_entry: got running=%b en=%b, want 0 0", bus.running, bus.cnt_enable);
    else passed++;
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.cnt_enable === 1'b1) n++;
    end
    checks++;
    if (n !== 0 || bus.count !== 3'd0)
      $display("FAIL pause_hold: got strobes=%0d count=%0d, want 0 0", n, bus.count);
    else passed++;
    pulse(1, 0, 0, 0);
    sb.push_back(mk(3'd1, 0, FIRST_GAP, 0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_strobe(cyc, wr);
      @(negedge clock);
      checks++;
      if (cyc !== e.gap || wr !== e.wraps || bus.count !== e.count || bus.wrap_pulse !== e.wrap)
        $display("FAIL resume_step: got gap=%0d wraps=%0d count=%0d wrap=%b, want gap=%0d wraps=%0d count=%0d wrap=%b",
                 cyc, wr, bus.count, bus.wrap_pulse, e.gap, e.wraps, e.count, e.wrap);
      else passed++;
    end
  endtask

  task automatic test_load();
    for (int v = 2; v <= 4; v++) sb.push_back(mk(v[W-1:0], 0, NEXT_GAP, 0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_strobe(cyc, wr);
      @(negedge clock);
      checks++;
      if (cyc !== e.gap || bus.count !== e.count || bus.wrap_pulse !== e.wrap)
        $display("FAIL load_pre_step: got gap=%0d count=%0d wrap=%b, want gap=%0d count=%0d wrap=%b",
                 cyc, bus.count, bus.wrap_pulse, e.gap, e.count, e.wrap);
      else passed++;
    end
    pulse(0, 1, 0, 0);
    bus.load_value = 3'b010;
    pulse(0, 0, 0, 1);
    checks++;
    if (bus.cnt_max_count !== 3'd2 || bus.cnt_clear !== 1'b1)
      $display("FAIL load_capture: got max=%0d clr=%b, want 2 1", bus.cnt_max_count, bus.cnt_clear);
    else passed++;
    @(negedge clock);
    checks++;
    if (bus.cnt_clear !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL load_clear: got clr=%b count=%0d, want 0 0", bus.cnt_clear, bus.count);
    else passed++;
    pulse(1, 0, 0, 0);
    sb.push_back(mk(3'd1, 0, FIRST_GAP, 0));
    sb.push_back(mk(3'd2, 0, NEXT_GAP, 0));
    sb.push_back(mk(3'd0, 1, NEXT_GAP, 0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_strobe(cyc, wr);
      @(negedge clock);
      checks++;
      if (cyc !== e.gap || wr !== e.wraps || bus.count !== e.count || bus.wrap_pulse !== e.wrap)
        $display("FAIL load_run_step: got gap=%0d wraps=%0d count=%0d wrap=%b, want gap=%0d wraps=%0d count=%0d wrap=%b",
                 cyc, wr, bus.count, bus.wrap_pulse, e.gap, e.wraps, e.count, e.wrap);
      else passed++;
    end
  endtask

  task automatic test_stop_idle();
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    checks++;
    if (bus.cnt_clear !== 1'b1 || bus.running !== 1'b0)
      $display("FAIL stop_stop_clear: got clr=%b run=%b, want 1 0", bus.cnt_clear, bus.running);
    else passed++;
    @(negedge clock);
    checks++;
    if (bus.cnt_clear !== 1'b0) $display("FAIL stop_stop_clear_len: got clr=%b, want 0", bus.cnt_clear);
    else passed++;
    bus.load_value = 3'b101;
    pulse(0, 0, 0, 1);
    checks++;
    if (bus.cnt_max_count !== 3'd5 || bus.cnt_clear !== 1'b0)
      $display("FAIL idle_load: got max=%0d clr=%b, want 5 0", bus.cnt_max_count, bus.cnt_clear);
    else passed++;
  endtask

  task automatic test_start_stop_idle();
    bus.load_value = 3'b011;
    pulse(1, 1, 0, 1);
    n = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.cnt_enable === 1'b1) n++;
    end
    checks++;
    if (bus.running !== 1'b0 || n !== 0 || bus.cnt_max_count !== 3'd5)
      $display("FAIL start_stop_idle: got run=%b strobes=%0d max=%0d, want 0 0 5", bus.running, n, bus.cnt_max_count);
    else passed++;
  endtask

  task automatic test_dir_toggle();
    pulse(0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pulse(1, 0, 0, 0);
    wait_strobe(cyc, wr);
    bus.dir_toggle = 1'b1;
    @(negedge clock);
    bus.dir_toggle = 1'b0;
    checks++;
    if (cyc !== FIRST_GAP || bus.count !== 3'd1 || bus.cnt_direction !== 1'b1)
      $display("FAIL dir_coincident: got gap=%0d count=%0d dir=%b, want %0d 1 1", cyc, bus.count, bus.cnt_direction, FIRST_GAP);
    else passed++;
    sb.push_back(mk(3'd0, 0, NEXT_GAP, 0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_strobe(cyc, wr);
      @(negedge clock);
      checks++;
      if (cyc !== e.gap || bus.count !== e.count || bus.wrap_pulse !== e.wrap)
        $display("FAIL dir_down_step: got gap=%0d count=%0d wrap=%b, want gap=%0d count=%0d wrap=%b",
                 cyc, bus.count, bus.wrap_pulse, e.gap, e.count, e.wrap);
      else passed++;
    end
  endtask

  task automatic test_bounce();
    pulse(1, 0, 0, 0);
    sb.push_back(mk(3'd1, 0, FIRST_GAP, 0));
    for (int v = 2; v <= 5; v++) sb.push_back(mk(v[W-1:0], 0, NEXT_GAP, 0));
    sb.push_back(mk(3'd4, 0, DWELL_GAP, 1));
    for (int v = 3; v >= 0; v--) sb.push_back(mk(v[W-1:0], 0, NEXT_GAP, 0));
    sb.push_back(mk(3'd1, 0, DWELL_GAP, 1));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_strobe(cyc, wr);
      @(negedge clock);
      checks++;
      if (cyc !== e.gap || wr !== e.wraps || bus.count !== e.count || bus.wrap_pulse !== e.wrap)
        $display("FAIL bounce_step: got gap=%0d wraps=%0d count=%0d wrap=%b, want gap=%0d wraps=%0d count=%0d wrap=%b",
                 cyc, wr, bus.count, bus.wrap_pulse, e.gap, e.wraps, e.count, e.wrap);
      else passed++;
    end
    checks++;
    if (bus.cnt_direction !== 1'b0) $display("FAIL bounce_dir: got dir=%b, want 0", bus.cnt_direction);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pulse(1, 0, 0, 0);
    sb.push_back(mk(3'd1, 0, FIRST_GAP, 0));
    sb.push_back(mk(3'd2, 0, NEXT_GAP, 0));
    sb.push_back(mk(3'd3, 0, NEXT_GAP, 0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      wait_strobe(cyc, wr);
      @(negedge clock);
      checks++;
      if (cyc !== e.gap || bus.count !== e.count)
        $display("FAIL midrun_step: got gap=%0d count=%0d, want gap=%0d count=%0d", cyc, bus.count, e.gap, e.count);
      else passed++;
    end
    // Step due in this cycle; reset between edges must cancel it.
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.cnt_enable, bus.cnt_direction, bus.cnt_max_count, bus.cnt_clear, bus.running, bus.wrap_pulse, bus.count}
        !== {1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 3'd0})
      $display("FAIL reset_async: got en=%b dir=%b max=%0d clr=%b run=%b wrap=%b count=%0d, want 0 0 5 0 0 0 0",
               bus.cnt_enable, bus.cnt_direction, bus.cnt_max_count, bus.cnt_clear, bus.running, bus.wrap_pulse, bus.count);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.cnt_enable === 1'b1) n++;
    end
    checks++;
    if (n !== 0 || bus.running !== 1'b0 || bus.count !== 3'd0)
      $display("FAIL reset_no_pending: got strobes=%0d run=%b count=%0d, want 0 0 0", n, bus.running, bus.count);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.dir_toggle = 1'b0; bus.load = 1'b0;
    bus.load_value = '0;
    test_reset();
`ifdef BOUNCE_MODE_EN
    test_bounce();
`else
    test_run();
    test_pause();
    test_load();
    test_stop_idle();
    test_start_stop_idle();
`endif
    test_dir_toggle();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule
